// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between fetch and data ports.
// Data port wins by default; a run counter forces fetch after MAX_RUN grants.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2,
  parameter int MAX_RUN = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  output logic          dm_stall,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t     state;
  logic       own_dm;
  logic [3:0] lat_cnt;
  logic [3:0] run_cnt;
  logic       pick_dm;
  logic       run_full;

  assign run_full = (run_cnt == 4'(MAX_RUN));
  assign pick_dm  = dm_req & ~(if_req & run_full);

  assign if_stall = if_req & ~if_ack;
  assign dm_stall = dm_req & ~dm_ack;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      own_dm    <= 1'b0;
      lat_cnt   <= '0;
      run_cnt   <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (if_req | dm_req) begin
            own_dm    <= pick_dm;
            ram_en    <= 1'b1;
            ram_we    <= pick_dm & dm_we;
            ram_addr  <= pick_dm ? dm_addr : if_addr;
            ram_wdata <= pick_dm ? dm_wdata : '0;
            lat_cnt   <= 4'(MEM_LAT - 1);
            state     <= ACCESS;
            // Only data grants that overtake a waiting fetch count.
            if (pick_dm && if_req)
              run_cnt <= run_full ? run_cnt : run_cnt + 4'd1;
            else
              run_cnt <= '0;
          end
        end
        ACCESS: begin
          if (lat_cnt != 4'd0) begin
            lat_cnt <= lat_cnt - 4'd1;
          end else begin
            if (!ram_we) begin
              if (own_dm) dm_rdata <= ram_rdata;
              else        if_rdata <= ram_rdata;
            end
            ram_en <= 1'b0;
            ram_we <= 1'b0;
            if_ack <= ~own_dm;
            dm_ack <= own_dm;
            state  <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter.
// Three instances with MEM_LAT 2, 1 and 5; the last two only run the sweep.
module tb_mem_port_arbiter;

  typedef struct {
    logic        is_dm;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_m;
  logic        rst_sw;
  logic [2:0]  if_req_v;
  logic [31:0] if_addr;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;

  logic [31:0] if_rdata_w  [3];
  logic        if_ack_w    [3];
  logic        if_stall_w  [3];
  logic [31:0] dm_rdata_w  [3];
  logic        dm_ack_w    [3];
  logic        dm_stall_w  [3];
  logic        ram_en_w    [3];
  logic        ram_we_w    [3];
  logic [31:0] ram_addr_w  [3];
  logic [31:0] ram_wdata_w [3];
  logic [31:0] ram_rdata_w [3];

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t exp_q [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input logic [7:0] i);
    return (i == 8'd4) ? 32'h2008_0005 : {24'hA0_0000, i};
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 5;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 5;
    int          en_cnt = 0;
    bit [255:0]  wr_v;
    logic [31:0] wmem [256];
    logic [7:0]  idx;
    logic [31:0] rd;

    assign idx = ram_addr_w[g][9:2];
    always_comb rd = wr_v[idx] ? wmem[idx] : init_word(idx);
    // Data only appears on the last ACCESS cycle; anything earlier is junk.
    assign ram_rdata_w[g] =
      (ram_en_w[g] && en_cnt == L - 1) ? rd : 32'hBAD0_BAD0;

    always @(posedge clk) begin
      en_cnt <= ram_en_w[g] ? en_cnt + 1 : 0;
      if (ram_en_w[g] && ram_we_w[g]) begin
        wr_v[idx] <= 1'b1;
        wmem[idx] <= ram_wdata_w[g];
      end
    end

    mem_port_arbiter #(
      .AW(32), .DW(32), .MEM_LAT(L), .MAX_RUN(4)
    ) u_dut (
      .clk       (clk),
      .rst       ((g == 0) ? rst_m : rst_sw),
      .if_req    (if_req_v[g]),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata_w[g]),
      .if_ack    (if_ack_w[g]),
      .if_stall  (if_stall_w[g]),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_rdata  (dm_rdata_w[g]),
      .dm_ack    (dm_ack_w[g]),
      .dm_stall  (dm_stall_w[g]),
      .ram_en    (ram_en_w[g]),
      .ram_we    (ram_we_w[g]),
      .ram_addr  (ram_addr_w[g]),
      .ram_wdata (ram_wdata_w[g]),
      .ram_rdata (ram_rdata_w[g])
    );
  end

  a_dm_stable: assert property (@(posedge clk)
    (dm_req && $past(dm_req)) |->
      ($stable(dm_addr) && $stable(dm_we) && $stable(dm_wdata)));
  a_if_stable: assert property (@(posedge clk)
    ((|if_req_v) && $past(|if_req_v)) |-> $stable(if_addr));

  function automatic void chk(input string nm, input logic [31:0] got,
                              input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, want, cyc);
    end
  endfunction

  function automatic void push(input int i, input logic is_dm,
                               input logic [31:0] data, input int c);
    exp_t e;
    e.is_dm = is_dm;
    e.data  = data;
    e.cyc   = c;
    exp_q[i].push_back(e);
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (if_ack_w[i] || dm_ack_w[i]) begin
          chk($sformatf("ack_onehot%0d", i),
              {31'b0, if_ack_w[i] & dm_ack_w[i]}, 32'd0);
          if (exp_q[i].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_ack%0d: if_ack %0b dm_ack %0b cycle %0d",
                     i, if_ack_w[i], dm_ack_w[i], cyc);
          end else begin
            e = exp_q[i].pop_front();
            chk($sformatf("ack_port%0d", i), {31'b0, dm_ack_w[i]},
                {31'b0, e.is_dm});
            chk($sformatf("ack_cycle%0d", i), 32'(cyc), 32'(e.cyc));
            chk($sformatf("ack_data%0d", i),
                e.is_dm ? dm_rdata_w[i] : if_rdata_w[i], e.data);
          end
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Requests drop in the cycle after their ack, so no re-request follows.
  task automatic serve();
    logic [2:0] keep_if;
    logic       keep_dm;
    int         t;
    t = 0;
    while ((if_req_v != 3'b000 || dm_req) && t < 60) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        keep_if[i] = if_req_v[i] & ~if_ack_w[i];
      keep_dm = dm_req & ~dm_ack_w[0];
      @(posedge clk);
      #1;
      if_req_v = keep_if;
      dm_req   = keep_dm;
      t++;
    end
    chk("serve_done", {31'b0, (if_req_v == 3'b000) && !dm_req}, 32'd1);
  endtask

  int c0;
  int n_ack;
  logic stall_ok;

  initial begin
    rst_m    = 1'b0;
    rst_sw   = 1'b0;
    if_req_v = 3'b001;
    if_addr  = 32'h20;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = 32'h0;
    dm_wdata = 32'h0;
    fork
      monitor();
    join_none

    // reset held 2 cycles with a pending fetch
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_ctrl", {28'b0, if_ack_w[0], dm_ack_w[0],
                       ram_en_w[0], ram_we_w[0]}, 32'd0);
      chk("rst_ram_addr", ram_addr_w[0], 32'd0);
      chk("rst_data", ram_wdata_w[0] | if_rdata_w[0] | dm_rdata_w[0], 32'd0);
    end
    @(posedge clk);
    #1;
    rst_m = 1'b1;
    c0 = cyc;
    push(0, 1'b0, 32'hA000_0008, c0 + 3);
    @(negedge clk);
    chk("rst_idle_en", {31'b0, ram_en_w[0]}, 32'd0);
    @(negedge clk);
    chk("rst_first_en", {31'b0, ram_en_w[0]}, 32'd1);
    serve();
    idle(2);

    // single fetch
    if_addr  = 32'h10;
    if_req_v = 3'b001;
    c0 = cyc;
    push(0, 1'b0, 32'h2008_0005, c0 + 3);
    @(negedge clk);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      chk($sformatf("fetch_en_c%0d", k), {31'b0, ram_en_w[0]}, 32'd1);
      chk($sformatf("fetch_addr_c%0d", k), ram_addr_w[0], 32'h10);
    end
    serve();
    idle(3);
    @(negedge clk);
    chk("fetch_hold", if_rdata_w[0], 32'h2008_0005);
    idle(1);

    // data write
    dm_we    = 1'b1;
    dm_addr  = 32'h40;
    dm_wdata = 32'hDEAD_BEEF;
    dm_req   = 1'b1;
    c0 = cyc;
    push(0, 1'b1, 32'h0, c0 + 3);
    @(negedge clk);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      chk($sformatf("wr_we_c%0d", k), {31'b0, ram_we_w[0]}, 32'd1);
      chk($sformatf("wr_wdata_c%0d", k), ram_wdata_w[0], 32'hDEAD_BEEF);
    end
    serve();
    idle(2);

    // data read back
    dm_we  = 1'b0;
    dm_req = 1'b1;
    c0 = cyc;
    push(0, 1'b1, 32'hDEAD_BEEF, c0 + 3);
    @(negedge clk);
    @(negedge clk);
    chk("rd_we", {31'b0, ram_we_w[0]}, 32'd0);
    serve();
    idle(2);

    // contention: DM x4, IF, DM
    if_addr  = 32'h10;
    dm_addr  = 32'h40;
    if_req_v = 3'b001;
    dm_req   = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 4; k++)
      push(0, 1'b1, 32'hDEAD_BEEF, c0 + 3 + 4 * k);
    push(0, 1'b0, 32'h2008_0005, c0 + 19);
    push(0, 1'b1, 32'hDEAD_BEEF, c0 + 23);
    n_ack = 0;
    stall_ok = 1'b1;
    for (int t = 0; t < 40 && n_ack < 6; t++) begin
      @(negedge clk);
      if (n_ack < 4 && if_stall_w[0] !== 1'b1) stall_ok = 1'b0;
      if (if_ack_w[0] || dm_ack_w[0]) n_ack++;
    end
    chk("cont_acks", 32'(n_ack), 32'd6);
    chk("cont_if_stall", {31'b0, stall_ok}, 32'd1);
    @(posedge clk);
    #1;
    if_req_v = 3'b000;
    dm_req   = 1'b0;
    idle(3);

    // reset during ACCESS of a data read
    dm_we  = 1'b0;
    dm_req = 1'b1;
    c0 = cyc;
    @(posedge clk);
    #1;
    rst_m = 1'b0;
    @(posedge clk);
    #1;
    rst_m = 1'b1;
    push(0, 1'b1, 32'hDEAD_BEEF, c0 + 5);
    @(negedge clk);
    chk("mid_rst_en", {31'b0, ram_en_w[0]}, 32'd0);
    chk("mid_rst_rdata", dm_rdata_w[0], 32'd0);
    serve();
    idle(2);

    // latency sweep on all three instances
    rst_m  = 1'b0;
    rst_sw = 1'b0;
    idle(2);
    rst_m  = 1'b1;
    rst_sw = 1'b1;
    idle(1);
    if_addr  = 32'h10;
    if_req_v = 3'b111;
    c0 = cyc;
    for (int i = 0; i < 3; i++)
      push(i, 1'b0, 32'h2008_0005, c0 + lat_of(i) + 1);
    serve();
    idle(2);
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("sweep_hold%0d", i), if_rdata_w[i], 32'h2008_0005);
    rst_sw = 1'b0;
    idle(4);

    for (int i = 0; i < 3; i++)
      chk($sformatf("pending%0d", i), 32'(exp_q[i].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
